vga_pixel_fetch: RTL and testbench
==================================

# vga_pixel_fetch

Display-side pixel stage directly downstream of the VGA timing generator. Takes its sync/blank strobes and its 128x32 pixel coordinates. Fetches RGB332 pixels from a double-banked framebuffer through a fixed-latency read port and expands them to 24-bit RGB. Re-aligns h_sync, v_sync and blank_n to the pixel data. Swaps the display bank on GPU request, only at the vertical-sync edge, so a frame is never torn.

## Interface
- X_BITS, 7, used low bits of pos_x (128 columns)
- Y_BITS, 5, used low bits of pos_y (32 rows)
- RD_LAT, 1, framebuffer read latency in cycles (legal 1..3)
- clk  input  1  pixel clock, same clock as the timing generator
- rst_n  input  1  reset, asynchronous, active-low
- h_sync_in  input  1  horizontal sync from timing generator (active-low pulse)
- v_sync_in  input  1  vertical sync from timing generator (active-low pulse)
- blank_n_in  input  1  1 = active video
- pos_x  input  10  pixel column; only [X_BITS-1:0] used
- pos_y  input  10  pixel row; only [Y_BITS-1:0] used
- fb_rd_en  output  1  framebuffer read strobe
- fb_rd_addr  output  1+Y_BITS+X_BITS  {disp_bank, pos_y, pos_x}
- fb_rd_data  input  8  RGB332 {r[2:0],g[2:0],b[1:0]}, valid RD_LAT cycles after fb_rd_en
- swap_req  input  1  level; GPU has finished drawing the back bank
- swap_ack  output  1  one-cycle pulse: swap done
- disp_bank  output  1  bank being displayed; the GPU draws into ~disp_bank
- vga_r, vga_g, vga_b  output  8 each  pixel colour
- h_sync, v_sync, blank_n  output  1 each  sync/blank delayed to match the pixel data

## Operation
- Pipeline depth D = RD_LAT+1.
  - Inputs sampled in cycle t appear on h_sync/v_sync/blank_n and on vga_* at the clock edge ending cycle t+D.
  - Implement with a D-stage shift register for the three strobes.
- Fetch rule, cycle t:
  - fb_rd_en = blank_n_in & (~last_valid | {pos_y,pos_x} != last_addr). Only the used bits are compared.
  - When fb_rd_en fires: last_addr <= used coordinates and last_valid <= 1.
  - blank_n_in = 0 clears last_valid.
  - A bank swap clears last_valid.
  - Net effect: one read per 5-cycle coordinate step, not one per clock.
- fb_rd_addr is combinational from the current inputs and disp_bank, and is meaningful only while fb_rd_en = 1.
- Read-return tracking: fb_rd_en is delayed RD_LAT cycles to give rd_valid. On rd_valid, pix_reg <= fb_rd_data. Otherwise pix_reg holds, because the coordinates have not changed.
- Colour expansion, registered from pix_reg:
  - vga_r = {r,r,r[2:1]}
  - vga_g = {g,g,g[2:1]}
  - vga_b = {b,b,b,b}
  - All three are forced to 0 when the delayed blank_n stage feeding that register is 0.
- Swap FSM, states IDLE and ACK:
  - IDLE, v_sync_in falling edge (prev 1, now 0) with swap_req = 1: toggle disp_bank, clear last_valid, assert swap_ack for one cycle, go to ACK.
  - ACK: swap_ack = 0. Return to IDLE when swap_req = 0, so a held request cannot swap twice.
  - swap_req rising mid-frame waits for the next v_sync edge.
  - swap_req dropped before the edge means no swap.
- Reset, asynchronous and active-low, in effect immediately at any point:
  - Outputs: h_sync, v_sync, blank_n, vga_r/g/b, swap_ack, disp_bank and fb_rd_en = 0.
  - Internal: delay pipes = 0, last_valid = 0, pix_reg = 0, v_sync edge detector prev = 1, FSM = IDLE.
  - Reads in flight at reset are discarded.

## Timing
- Fetch latency: fb_rd_en in cycle t, data captured at end of t+RD_LAT, colour visible in cycle t+D.
- Sync/blank skew: vga_* and the delayed strobes always change on the same edge.
- swap_ack is high in the cycle right after the edge-detect cycle. disp_bank changes on that same edge.
- Simultaneous events:
  - Swap edge and blank_n_in = 1 cannot occur together, because v_sync lies in vertical blank.
  - If they do occur, the swap still clears last_valid and the next fetch uses the new bank.
- Coordinate wrap from x=127 to 0, or from y=31 to 0: the address differs, so a fetch occurs normally.

## Test plan
- Reset release, idle inputs (all strobes 1, blank_n_in = 0): all outputs 0, fb_rd_en never asserts, swap_ack = 0.
- Active line, pos_x steps 0,1,2 every 5 cycles, RD_LAT = 1, memory returns 8'hE0 then 8'h1C then 8'h03:
  - exactly 3 fb_rd_en pulses;
  - vga = (FF,00,00) for 5 cycles, then (00,FF,00), then (00,00,FF);
  - each colour starts 2 cycles after its fetch.
- RD_LAT = 3: same stimulus gives identical colour sequences shifted by 4 cycles, with h_sync, v_sync and blank_n also shifted by 4 cycles.
- blank_n_in falls mid-pixel: fetching stops, and vga_* = 0 from exactly D cycles after the fall.
- Swap request:
  - swap_req = 1 mid-frame: disp_bank unchanged until v_sync_in falls;
  - at that edge disp_bank toggles, swap_ack pulses exactly once, and the next frame's fb_rd_addr MSB = 1;
  - holding swap_req through a second v_sync edge gives no second swap.
- rst_n asserted mid-line with a read in flight: outputs 0 in the same cycle; after release, the first active pixel is fetched from bank 0.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Pixel stage behind the VGA timing generator: fetches RGB332 pixels from a
// double-banked framebuffer, expands them to RGB888 and re-aligns sync/blank.
module vga_pixel_fetch #(
    parameter int X_BITS = 7,
    parameter int Y_BITS = 5,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     h_sync_in,
    input  logic                     v_sync_in,
    input  logic                     blank_n_in,
    input  logic [9:0]               pos_x,
    input  logic [9:0]               pos_y,
    output logic                     fb_rd_en,
    output logic [X_BITS+Y_BITS:0]   fb_rd_addr,
    input  logic [7:0]               fb_rd_data,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     disp_bank,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic                     blank_n
);

    localparam int D  = RD_LAT + 1;
    localparam int AW = X_BITS + Y_BITS;

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    state_t            r_state;
    logic              r_vs_prev;
    logic              r_last_valid;
    logic [AW-1:0]     r_last_addr;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [D-1:0]      r_hs_d;
    logic [D-1:0]      r_vs_d;
    logic [D-1:0]      r_bl_d;
    logic [7:0]        r_pix;

    logic [AW-1:0]     w_coord;
    logic              w_fetch;
    logic              w_swap;
    logic              w_rd_valid;
    logic [7:0]        w_pix_next;
    logic              w_unused;

    assign w_unused   = &{1'b0, pos_x[9:X_BITS], pos_y[9:Y_BITS]};
    assign w_coord    = {pos_y[Y_BITS-1:0], pos_x[X_BITS-1:0]};
    // A pixel spans several clocks; only fetch when the coordinate changes.
    assign w_fetch    = blank_n_in & (~r_last_valid | (w_coord != r_last_addr));
    assign fb_rd_en   = w_fetch & rst_n;
    assign fb_rd_addr = {disp_bank, w_coord};
    assign w_swap     = (r_state == S_IDLE) & r_vs_prev & ~v_sync_in & swap_req;
    assign w_rd_valid = r_rd_pipe[RD_LAT-1];
    assign w_pix_next = w_rd_valid ? fb_rd_data : r_pix;

    assign h_sync  = r_hs_d[D-1];
    assign v_sync  = r_vs_d[D-1];
    assign blank_n = r_bl_d[D-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
            r_rd_pipe    <= '0;
            r_hs_d       <= '0;
            r_vs_d       <= '0;
            r_bl_d       <= '0;
        end else begin
            r_rd_pipe <= RD_LAT'({r_rd_pipe, w_fetch});
            r_hs_d    <= D'({r_hs_d, h_sync_in});
            r_vs_d    <= D'({r_vs_d, v_sync_in});
            r_bl_d    <= D'({r_bl_d, blank_n_in});
            if (w_fetch) begin
                r_last_addr <= w_coord;
            end
            // A swap invalidates the cached coordinate so the new bank is read.
            if (w_swap || !blank_n_in) begin
                r_last_valid <= 1'b0;
            end else if (w_fetch) begin
                r_last_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= 8'h00;
            vga_r <= 8'h00;
            vga_g <= 8'h00;
            vga_b <= 8'h00;
        end else begin
            r_pix <= w_pix_next;
            if (r_bl_d[D-2]) begin
                vga_r <= {w_pix_next[7:5], w_pix_next[7:5], w_pix_next[7:6]};
                vga_g <= {w_pix_next[4:2], w_pix_next[4:2], w_pix_next[4:3]};
                vga_b <= {4{w_pix_next[1:0]}};
            end else begin
                vga_r <= 8'h00;
                vga_g <= 8'h00;
                vga_b <= 8'h00;
            end
        end
    end

    // Bank swap only on the v_sync falling edge; ACK waits for the request to drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_vs_prev <= 1'b1;
            swap_ack  <= 1'b0;
            disp_bank <= 1'b0;
        end else begin
            r_vs_prev <= v_sync_in;
            swap_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_swap) begin
                        disp_bank <= ~disp_bank;
                        swap_ack  <= 1'b1;
                        r_state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!swap_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: one instance with RD_LAT=1 and one with
// RD_LAT=3 share the stimulus, each with its own fixed-latency memory model.
module tb_vga_pixel_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       h_sync_in, v_sync_in, blank_n_in, swap_req;
    logic [9:0] pos_x, pos_y;

    logic        en1, ack1, bank1, hs1, vs1, bl1;
    logic [12:0] addr1;
    logic [7:0]  data1, r1, g1, b1;
    logic        en3, ack3, bank3, hs3, vs3, bl3;
    logic [12:0] addr3;
    logic [7:0]  data3, r3, g3, b3;

    int checks   = 0;
    int failures = 0;

    vga_pixel_fetch #(.X_BITS(7), .Y_BITS(5), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .blank_n_in(blank_n_in), .pos_x(pos_x), .pos_y(pos_y),
        .fb_rd_en(en1), .fb_rd_addr(addr1), .fb_rd_data(data1),
        .swap_req(swap_req), .swap_ack(ack1), .disp_bank(bank1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .h_sync(hs1), .v_sync(vs1), .blank_n(bl1)
    );

    vga_pixel_fetch #(.X_BITS(7), .Y_BITS(5), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .blank_n_in(blank_n_in), .pos_x(pos_x), .pos_y(pos_y),
        .fb_rd_en(en3), .fb_rd_addr(addr3), .fb_rd_data(data3),
        .swap_req(swap_req), .swap_ack(ack3), .disp_bank(bank3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .h_sync(hs3), .v_sync(vs3), .blank_n(bl3)
    );

    function automatic logic [7:0] mem_rd(input logic [12:0] a);
        case (a[6:0])
            7'd0:    return 8'hE0;
            7'd1:    return 8'h1C;
            7'd2:    return 8'h03;
            7'd5:    return 8'h92;
            7'd6:    return 8'h49;
            default: return 8'h6D;
        endcase
    endfunction

    // Memory models: garbage when not reading so stray captures show up.
    logic [7:0] m1, m3a, m3b, m3c;
    always @(posedge clk) begin
        m1  <= en1 ? mem_rd(addr1) : 8'hA5;
        m3a <= en3 ? mem_rd(addr3) : 8'hA5;
        m3b <= m3a;
        m3c <= m3b;
    end
    assign data1 = m1;
    assign data3 = m3c;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; blank_n_in = 1'b0;
        swap_req = 1'b0; pos_x = '0; pos_y = '0;
        @(negedge clk);
        checks++;
        if ({en1, ack1, bank1, hs1, vs1, bl1, r1, g1, b1, en3, ack3, bank3, hs3, vs3, bl3, r3, g3, b3} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got dut1=%b%b%b%b%b%b %h%h%h dut3=%b%b%b%b%b%b %h%h%h exp all 0",
                     en1, ack1, bank1, hs1, vs1, bl1, r1, g1, b1, en3, ack3, bank3, hs3, vs3, bl3, r3, g3, b3);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({en1, en3, ack1, ack3, bank1, bank3, bl1, bl3, r1, g1, b1, r3, g3, b3} !== '0) begin
                failures++;
                $display("FAIL idle_quiet c=%0d got en=%b%b ack=%b%b bank=%b%b bl=%b%b vga1=%h%h%h vga3=%h%h%h exp 0",
                         c, en1, en3, ack1, ack3, bank1, bank3, bl1, bl3, r1, g1, b1, r3, g3, b3);
            end
            checks++;
            if ({hs1, vs1, hs3, vs3} !== {{2{c >= 2}}, {2{c >= 4}}}) begin
                failures++;
                $display("FAIL idle_sync_delay c=%0d got %b%b%b%b exp %b%b%b%b", c, hs1, vs1, hs3, vs3,
                         c >= 2, c >= 2, c >= 4, c >= 4);
            end
            next_cycle();
        end
    endtask

    task automatic test_active_line();
        int n1 = 0;
        int n3 = 0;
        for (int c = 0; c < 22; c++) begin
            logic        exp_en;
            logic [23:0] c1, c3;
            blank_n_in = (c < 15);
            pos_x      = 10'((c < 15) ? c / 5 : 2);
            pos_y      = 10'd0;
            h_sync_in  = !(c == 3 || c == 4);
            v_sync_in  = 1'b1;
            @(negedge clk);
            exp_en = (c == 0 || c == 5 || c == 10);
            n1 += int'(en1);
            n3 += int'(en3);
            checks++;
            if ({en1, en3} !== {exp_en, exp_en}) begin
                failures++;
                $display("FAIL line_rd_en c=%0d got %b%b exp %b%b", c, en1, en3, exp_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (addr1 !== 13'(c / 5) || addr3 !== 13'(c / 5)) begin
                    failures++;
                    $display("FAIL line_rd_addr c=%0d got %h/%h exp %h", c, addr1, addr3, 13'(c / 5));
                end
            end
            c1 = (c >= 2 && c < 7) ? 24'hFF0000 : (c >= 7 && c < 12) ? 24'h00FF00 :
                 (c >= 12 && c < 17) ? 24'h0000FF : 24'h0;
            c3 = (c >= 4 && c < 9) ? 24'hFF0000 : (c >= 9 && c < 14) ? 24'h00FF00 :
                 (c >= 14 && c < 19) ? 24'h0000FF : 24'h0;
            checks++;
            if ({r1, g1, b1} !== c1) begin
                failures++;
                $display("FAIL line_vga_lat1 c=%0d got %h%h%h exp %h", c, r1, g1, b1, c1);
            end
            checks++;
            if ({r3, g3, b3} !== c3) begin
                failures++;
                $display("FAIL line_vga_lat3 c=%0d got %h%h%h exp %h", c, r3, g3, b3, c3);
            end
            checks++;
            if ({bl1, hs1, bl3, hs3} !== {c >= 2 && c < 17, !(c == 5 || c == 6),
                                          c >= 4 && c < 19, !(c == 7 || c == 8)}) begin
                failures++;
                $display("FAIL line_strobes c=%0d got bl1=%b hs1=%b bl3=%b hs3=%b", c, bl1, hs1, bl3, hs3);
            end
            next_cycle();
        end
        checks++;
        if (n1 != 3 || n3 != 3) begin
            failures++;
            $display("FAIL line_rd_count got %0d/%0d exp 3/3", n1, n3);
        end
    endtask

    task automatic test_blank_fall();
        for (int c = 0; c < 13; c++) begin
            logic        exp_en;
            logic [23:0] c1, c3;
            blank_n_in = (c < 7);
            pos_x      = 10'((c < 5) ? 5 : (c < 9) ? 6 : 7);
            pos_y      = 10'd0;
            @(negedge clk);
            exp_en = (c == 0 || c == 5);
            checks++;
            if ({en1, en3} !== {exp_en, exp_en}) begin
                failures++;
                $display("FAIL blank_rd_en c=%0d got %b%b exp %b", c, en1, en3, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (addr1 !== 13'(pos_x)) begin
                    failures++;
                    $display("FAIL blank_rd_addr c=%0d got %h exp %h", c, addr1, 13'(pos_x));
                end
            end
            c1 = (c >= 2 && c < 7) ? 24'h9292AA : (c >= 7 && c < 9) ? 24'h494955 : 24'h0;
            c3 = (c >= 4 && c < 9) ? 24'h9292AA : (c >= 9 && c < 11) ? 24'h494955 : 24'h0;
            checks++;
            if ({r1, g1, b1} !== c1 || {r3, g3, b3} !== c3) begin
                failures++;
                $display("FAIL blank_vga c=%0d got %h%h%h/%h%h%h exp %h/%h", c, r1, g1, b1, r3, g3, b3, c1, c3);
            end
            next_cycle();
        end
    endtask

    task automatic test_swap();
        logic vs_hist[18];
        for (int c = 0; c < 18; c++) begin
            logic        exp_bank, exp_ack, exp_en, ev1, ev3;
            logic [12:0] exp_addr;
            swap_req   = (c <= 8) || (c == 12 || c == 13);
            v_sync_in  = !(c == 3 || c == 4 || c == 6 || c == 7 || c == 15 || c == 16);
            blank_n_in = (c <= 2) || (c == 10 || c == 11);
            pos_x      = (c <= 2) ? 10'd10 : 10'd0;
            pos_y      = (c >= 10) ? 10'd1 : 10'd0;
            vs_hist[c] = v_sync_in;
            @(negedge clk);
            exp_bank = (c >= 4);
            exp_ack  = (c == 4);
            exp_en   = (c == 0 || c == 10);
            exp_addr = (c == 0) ? 13'd10 : 13'h1080;
            checks++;
            if ({bank1, bank3, ack1, ack3} !== {exp_bank, exp_bank, exp_ack, exp_ack}) begin
                failures++;
                $display("FAIL swap_bank_ack c=%0d got bank=%b%b ack=%b%b exp bank=%b ack=%b",
                         c, bank1, bank3, ack1, ack3, exp_bank, exp_ack);
            end
            checks++;
            if ({en1, en3} !== {exp_en, exp_en}) begin
                failures++;
                $display("FAIL swap_rd_en c=%0d got %b%b exp %b", c, en1, en3, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (addr1 !== exp_addr || addr3 !== exp_addr) begin
                    failures++;
                    $display("FAIL swap_rd_addr c=%0d got %h/%h exp %h", c, addr1, addr3, exp_addr);
                end
            end
            ev1 = (c >= 2) ? vs_hist[c-2] : 1'b1;
            ev3 = (c >= 4) ? vs_hist[c-4] : 1'b1;
            checks++;
            if ({vs1, vs3} !== {ev1, ev3}) begin
                failures++;
                $display("FAIL swap_vsync_delay c=%0d got %b%b exp %b%b", c, vs1, vs3, ev1, ev3);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_line();
        blank_n_in = 1'b1; pos_x = 10'd20; pos_y = 10'd2;
        v_sync_in = 1'b1; h_sync_in = 1'b1; swap_req = 1'b0;
        @(negedge clk);
        checks++;
        if (en1 !== 1'b1 || addr1 !== 13'd4372) begin
            failures++;
            $display("FAIL rst_pre_fetch got en=%b addr=%h exp en=1 addr=%h", en1, addr1, 13'd4372);
        end
        next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en1, ack1, bank1, hs1, vs1, bl1, r1, g1, b1, en3, ack3, bank3, hs3, vs3, bl3, r3, g3, b3} !== '0) begin
            failures++;
            $display("FAIL rst_async_outputs got dut1=%b%b%b%b%b%b %h%h%h dut3=%b%b%b%b%b%b %h%h%h exp all 0",
                     en1, ack1, bank1, hs1, vs1, bl1, r1, g1, b1, en3, ack3, bank3, hs3, vs3, bl3, r3, g3, b3);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 3; c < 8; c++) begin
            logic [23:0] c1, c3;
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if ({en1, en3} !== 2'b11 || addr1 !== 13'd276 || addr3 !== 13'd276) begin
                    failures++;
                    $display("FAIL rst_first_fetch got en=%b%b addr=%h/%h exp en=11 addr=%h",
                             en1, en3, addr1, addr3, 13'd276);
                end
            end
            c1 = (c >= 5) ? 24'h6D6D55 : 24'h0;
            c3 = (c >= 7) ? 24'h6D6D55 : 24'h0;
            checks++;
            if ({r1, g1, b1} !== c1 || {r3, g3, b3} !== c3) begin
                failures++;
                $display("FAIL rst_vga c=%0d got %h%h%h/%h%h%h exp %h/%h", c, r1, g1, b1, r3, g3, b3, c1, c3);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_active_line();
        test_blank_fall();
        test_swap();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
